uart_rx: RTL

//  Parametrised UART receiver: next generation of the fixed 8-bit odd-parity receiver.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_baud_timer.sv | 37 +++
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and the
// parametrised transmitter that will reuse it.
//   parity_t     parity mode selector (none / even / odd)
//   rx_state_t   receiver FSM state encoding
//   UART_CLKS_PER_BIT_DEFAULT  default bit period in clk cycles
//   parity_error helper: error flag from the XOR of the data bits and the
//                received parity bit
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 5208;

  // data_xor is the reduction XOR of the received data bits.
  function automatic logic parity_error(parity_t mode, logic data_xor, logic par_bit);
    case (mode)
      PAR_EVEN: return data_xor ^ par_bit;
      PAR_ODD:  return ~(data_xor ^ par_bit);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake between the UART receiver and its
// consumer (command decoder).
//   rx_ack      consumer -> receiver  accept the held frame this cycle
//   rx_valid    receiver -> consumer  rx_data and flags hold a frame
//   rx_data     receiver -> consumer  received data word, DATA_BITS wide
//   parity_err  receiver -> consumer  parity mismatch on the held frame
//   frame_err   receiver -> consumer  stop bit sampled low on the held frame
//   overrun     receiver -> consumer  sticky, a frame was dropped while held
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if #(parameter int DATA_BITS = 8);

  logic                 rx_ack;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    input  rx_ack,
    output rx_valid, rx_data, parity_err, frame_err, overrun
  );

  modport slave (
    output rx_ack,
    input  rx_valid, rx_data, parity_err, frame_err, overrun
  );

endinterface

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: bit-period timer for the UART receiver.
// Counts 0..CLKS_PER_BIT-1 and wraps, so it never overflows.
//   clk        clock
//   Reset      synchronous, active-high reset
//   clr        restart the count at 0 on the next edge
//   half_tick  count == CLKS_PER_BIT/2 - 1 (half a bit period after clear)
//   full_tick  count == CLKS_PER_BIT - 1   (one bit period after clear/wrap)
module uart_baud_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF_M1 = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] LAST    = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (Reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign half_tick = (cnt == HALF_M1);
  assign full_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: parametrised UART receiver with valid/ack output handshake and a
// one-frame holding register.
//   clk    clock
//   Reset  synchronous, active-high reset (aborts a frame in progress)
//   Sin    asynchronous serial input, idle high
//   rx     uart_rx_if.master: rx_ack in; rx_valid, rx_data, parity_err,
//          frame_err, overrun out
// Parameters: CLKS_PER_BIT (>= 8), DATA_BITS (5..9, LSB first), PARITY.
// Build option: define UART_RX_MAJORITY_EN to take every bit sample as the
// 2-of-3 majority of sin_s around the sample instant; timing is unchanged.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for sin_s low (start edge)
// START     | half a bit into start bit; high again means false start
// DATA      | sampling data bits at bit centres, shifting in at the MSB
// PARITY    | sampling the parity bit (skipped when PARITY == PAR_NONE)
// STOP      | sampling the stop bit, then loading the output register
// WAIT_HIGH | stop bit was low (break/framing error), wait for line high
module uart_rx
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PAR_ODD
) (
  input  logic     clk,
  input  logic     Reset,
  input  logic     Sin,
  uart_rx_if.master rx
);

  localparam logic [2:0] ST_IDLE      = RX_IDLE;
  localparam logic [2:0] ST_START     = RX_START;
  localparam logic [2:0] ST_DATA      = RX_DATA;
  localparam logic [2:0] ST_PARITY    = RX_PARITY;
  localparam logic [2:0] ST_STOP      = RX_STOP;
  localparam logic [2:0] ST_WAIT_HIGH = RX_WAIT_HIGH;

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic                 sin_s1;
  logic                 sin_s;
  logic                 sample;
  logic [2:0]           state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q;
  logic                 half_tick;
  logic                 full_tick;
  logic                 timer_clr;
  logic                 frame_done;

  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_o;
  logic                 ferr_o;
  logic                 ovr_q;

  // Synchroniser resets to the idle level so reset release cannot look like
  // a start edge.
  always_ff @(posedge clk) begin
    if (Reset) begin
      sin_s1 <= 1'b1;
      sin_s  <= 1'b1;
    end else begin
      sin_s1 <= Sin;
      sin_s  <= sin_s1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // sin_s one cycle ahead is already sitting in sin_s1, so the +1 vote is
  // available at instant 0 without shifting the decision point. If sin_s1 is
  // unresolved, the other two votes decide whenever they agree.
  logic sin_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      sin_d <= 1'b1;
    end else begin
      sin_d <= sin_s;
    end
  end

  assign sample = (sin_d & sin_s) | (sin_d & sin_s1) | (sin_s & sin_s1);
`else
  assign sample = sin_s;
`endif

  // Held clear while idle; re-cleared at the start-bit centre so that every
  // later full_tick lands on a bit centre.
  assign timer_clr = (state == ST_IDLE) || ((state == ST_START) && half_tick);

  uart_baud_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .Reset     (Reset),
    .clr       (timer_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  assign frame_done = (state == ST_STOP) && full_tick;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      perr_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!sin_s) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          if (half_tick) begin
            bit_cnt <= '0;
            perr_q  <= 1'b0;
            state   <= sample ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (full_tick) begin
            shreg <= {sample, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (full_tick) begin
            perr_q <= parity_error(PARITY, ^shreg, sample);
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_tick) begin
            state <= sample ? ST_IDLE : ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (sin_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding register. A completing frame is accepted if the slot is empty or
  // being acked in the same cycle; otherwise it is dropped and overrun set.
  always_ff @(posedge clk) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      perr_o  <= 1'b0;
      ferr_o  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (frame_done) begin
      if (!valid_q || rx.rx_ack) begin
        valid_q <= 1'b1;
        data_q  <= shreg;
        perr_o  <= perr_q;
        ferr_o  <= ~sample;
        ovr_q   <= 1'b0;
      end else begin
        ovr_q   <= 1'b1;
      end
    end else if (valid_q && rx.rx_ack) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx.rx_valid   = valid_q;
  assign rx.rx_data    = data_q;
  assign rx.parity_err = perr_o;
  assign rx.frame_err  = ferr_o;
  assign rx.overrun    = ovr_q;

endmodule
